myproject_mac_pipe_16s_6s: RTL

MYPROJECT_MAC_PIPE_16S_6S -- requirements
Module: myproject_mac_pipe_16s_6s

---
 rtl/myproject_mac_pipe_16s_6s.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/myproject_mac_pipe_16s_6s.sv
// Pipelined signed multiply / multiply-accumulate with saturation.
// Stage 1 registers the inputs, stages 2..NUM_STAGE-1 carry the product, and the last stage accumulates and saturates.
module myproject_mac_pipe_16s_6s #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 6,
  parameter int DOUT_WIDTH = 22,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STAGE  = 3
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ce,
  input  logic                         in_vld,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         acc_en,
  input  logic                         acc_clr,
  output logic                         out_vld,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int PD = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 1;

  localparam logic signed [ACC_WIDTH-1:0] DMAX =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DMIN =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic                         s1_vld, s1_en, s1_clr;
  logic signed [DIN0_WIDTH-1:0] s1_a;
  logic signed [DIN1_WIDTH-1:0] s1_b;
  logic signed [PW-1:0]         prod;

  logic                         t_vld, t_en, t_clr;
  logic signed [PW-1:0]         t_p;

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_nxt, p_ext, acc_clamped, res;
  logic signed [ACC_WIDTH:0]    sum;
  logic                         acc_sat, aovf, dhi, dlo;
  logic signed [DOUT_WIDTH-1:0] dout_nxt;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_vld <= 1'b0;
      s1_en  <= 1'b0;
      s1_clr <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else if (ce) begin
      s1_vld <= in_vld;
      s1_en  <= acc_en;
      s1_clr <= acc_clr;
      s1_a   <= din0;
      s1_b   <= din1;
    end
  end

  // Operands widened first so the product keeps full precision.
  assign prod = PW'(s1_a) * PW'(s1_b);

  generate
    if (NUM_STAGE > 2) begin : g_ppipe
      logic                 pp_vld [PD];
      logic                 pp_en  [PD];
      logic                 pp_clr [PD];
      logic signed [PW-1:0] pp_p   [PD];

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int i = 0; i < PD; i++) begin
            pp_vld[i] <= 1'b0;
            pp_en[i]  <= 1'b0;
            pp_clr[i] <= 1'b0;
            pp_p[i]   <= '0;
          end
        end else if (ce) begin
          pp_vld[0] <= s1_vld;
          pp_en[0]  <= s1_en;
          pp_clr[0] <= s1_clr;
          pp_p[0]   <= prod;
          for (int i = 1; i < PD; i++) begin
            pp_vld[i] <= pp_vld[i-1];
            pp_en[i]  <= pp_en[i-1];
            pp_clr[i] <= pp_clr[i-1];
            pp_p[i]   <= pp_p[i-1];
          end
        end
      end

      assign t_vld = pp_vld[PD-1];
      assign t_en  = pp_en[PD-1];
      assign t_clr = pp_clr[PD-1];
      assign t_p   = pp_p[PD-1];
    end else begin : g_pdirect
      assign t_vld = s1_vld;
      assign t_en  = s1_en;
      assign t_clr = s1_clr;
      assign t_p   = prod;
    end
  endgenerate

  assign p_ext = ACC_WIDTH'(t_p);
  assign sum   = {acc_q[ACC_WIDTH-1], acc_q} + {p_ext[ACC_WIDTH-1], p_ext};

  // Sign disagreement between the two top bits means the sum left the ACC range.
  assign acc_sat     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  assign acc_clamped = acc_sat ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}}
                               : sum[ACC_WIDTH-1:0];

  always_comb begin
    res     = p_ext;
    acc_nxt = acc_q;
    aovf    = 1'b0;
    if (t_en) begin
      if (t_clr) begin
        acc_nxt = p_ext;
      end else begin
        acc_nxt = acc_clamped;
        aovf    = acc_sat;
        res     = acc_clamped;
      end
    end
  end

  assign dhi      = (res > DMAX);
  assign dlo      = (res < DMIN);
  assign dout_nxt = dhi ? DMAX[DOUT_WIDTH-1:0] :
                    dlo ? DMIN[DOUT_WIDTH-1:0] : res[DOUT_WIDTH-1:0];

  // Bubbles keep acc, dout and ovf at their last values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc_q   <= '0;
      out_vld <= 1'b0;
      dout    <= '0;
      ovf     <= 1'b0;
    end else if (ce) begin
      out_vld <= t_vld;
      if (t_vld) begin
        acc_q <= acc_nxt;
        dout  <= dout_nxt;
        ovf   <= aovf | dhi | dlo;
      end
    end
  end

endmodule
